// File: rtl/spsram32_arbiter.sv
// Round-robin or fixed-priority arbiter that shares one single-port 32-bit SRAM
// between an instruction-fetch port and a byte-masked data port.
//
// state | meaning
// IDLE  | no ack pending this cycle
// ACK_I | instr_ack high, instr_rdata valid
// ACK_D | data_ack high, data read valid or write committed
module spsram32_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_ack,
  output logic [31:0] instr_rdata,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_we,
  input  logic [3:0]  data_mask,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACK_I, ACK_D} state_e;
  typedef enum logic {LG_INSTR, LG_DATA} last_grant_e;

  state_e      state_q, state_d;
  last_grant_e last_grant_q, last_grant_d;

  logic elig_i, elig_d;
  logic grant_i, grant_d;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q      <= IDLE;
      last_grant_q <= LG_DATA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign instr_ack   = (state_q == ACK_I);
  assign data_ack    = (state_q == ACK_D);
  assign instr_rdata = mem_rdata;
  assign data_rdata  = mem_rdata;

  always_comb begin
    elig_i       = instr_req & ~instr_ack;
    elig_d       = data_req & ~data_ack;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    state_d      = IDLE;
    last_grant_d = last_grant_q;

    if (elig_i && elig_d) begin
      // A port still in its ack cycle is never eligible, so the other port
      // can take the slot and contention keeps the SRAM busy every cycle.
      if (FIXED_PRIORITY || (last_grant_q == LG_INSTR)) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b1;
      end
    end else begin
      grant_i = elig_i;
      grant_d = elig_d;
    end

    if (grant_i) begin
      state_d      = ACK_I;
      last_grant_d = LG_INSTR;
    end else if (grant_d) begin
      state_d      = ACK_D;
      last_grant_d = LG_DATA;
    end
  end

  always_comb begin
    mem_en      = grant_i | grant_d;
    mem_addr    = grant_d ? data_addr : instr_addr;
    mem_wdata   = data_wdata;
    mem_wr_en   = grant_d & data_we;
    mem_wr_mask = (grant_d & data_we) ? data_mask : 4'b0000;
  end

endmodule

// File: doc/spsram32_arbiter.md
Name: spsram32_arbiter

Overview:
Two-requester arbiter that shares one 32-bit single-port SRAM between the core's instruction-fetch port (read-only) and data port (read/write, byte-masked). It sits between the core's fetch/LSU bus ports and the SRAM instance. It decides who owns the SRAM each cycle, drives the SRAM control signals for that requester, and returns a one-cycle ack when the SRAM read data is valid. Arbitration is round-robin, or fixed priority when configured.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between instr and data; 1 = data always wins a conflict.

Ports:
clk  input  1  clock; all state updates on rising edge
rstz  input  1  asynchronous active-low reset
instr_addr  input  32  fetch byte address
instr_req  input  1  fetch request; held high until instr_ack
instr_ack  output  1  one-cycle ack; instr_rdata valid this cycle
instr_rdata  output  32  fetch read data
data_addr  input  32  data byte address
data_wdata  input  32  write data
data_we  input  1  1 = write, 0 = read
data_mask  input  4  byte-lane write enables
data_req  input  1  data request; held high until data_ack
data_ack  output  1  one-cycle ack; read data valid, or write committed
data_rdata  output  32  data read data
mem_addr  output  32  to SRAM addr
mem_wdata  output  32  to SRAM wdata
mem_en  output  1  to SRAM en
mem_wr_en  output  1  to SRAM wr_en
mem_wr_mask  output  4  to SRAM wr_mask
mem_rdata  input  32  from SRAM rdata; registered, valid the cycle after en

Behaviour:
- Reset (rstz low, async):
  - instr_ack = 0 and data_ack = 0.
  - FSM returns to IDLE.
  - The round-robin pointer last_grant is set to DATA, so instr wins the first conflict.
  - SRAM-side outputs are combinational. With no eligible requests they drive mem_en=0, mem_wr_en=0, mem_wr_mask=0.
- FSM states are IDLE, ACK_I and ACK_D. ACK_I and ACK_D are encoded in the registered instr_ack and data_ack; at most one is set at a time.
- Eligibility, evaluated combinationally each cycle:
  - elig_i = instr_req & ~instr_ack
  - elig_d = data_req & ~data_ack
  - A port cannot be re-granted in its own ack cycle, because the requester still holds req during ack.
- Grant:
  - Only one port eligible: that port wins.
  - Both eligible, FIXED_PRIORITY=0: the port that is not last_grant wins.
  - Both eligible, FIXED_PRIORITY=1: data wins.
  - last_grant is updated to the winner on every grant.
- SRAM drive in the grant cycle:
  - mem_en = 1.
  - mem_addr is the winner's address.
  - mem_wdata = data_wdata.
  - mem_wr_en = grant_d & data_we.
  - mem_wr_mask = data_mask if it is a data write, else 0.
  - No grant: mem_addr = instr_addr, mem_wdata = data_wdata, and the enables are 0.
- Ack latency is fixed at 1 cycle. A grant in cycle N gives the winner's ack = 1 in cycle N+1 only; ack is deasserted in N+2 unless the port is granted again.
- instr_rdata and data_rdata are wired directly from mem_rdata. They are valid only in their ack cycle.
- Throughput:
  - In an ACK cycle the other port may be granted (back-to-back cross-port access), giving 100% SRAM utilisation under contention.
  - A single port alone gets at most one access every 2 cycles.
- Starvation bound (round-robin): with both ports continuously requesting, grants strictly alternate I, D, I, D...
- Requests dropped before ack are a protocol violation and are not checked. A grant already issued still produces its ack, and a write is still committed.
- Reset mid-access: acks clear immediately. An SRAM write issued on the edge before reset is committed. No pending grant is remembered.
- mask = 0 on a data write still consumes a slot and is acked; memory is unchanged.
- Addresses are passed through untruncated; word selection is done by the SRAM.

Test Plan:
- Reset, then instr_req=1 with instr_addr=0x10 and word 4 preloaded with 0xDEADBEEF:
  - mem_en=1 in the first cycle, instr_ack=1 in the next cycle, instr_rdata=0xDEADBEEF.
  - With instr_req held, the next grant comes after the ack cycle (1 access per 2 cycles).
- Data write to addr 0x20, wdata=0x11223344, mask=4'b0101, then data read of 0x20 (word preloaded 0xAABBCCDD):
  - The write gets mem_wr_en=1, mem_wr_mask=4'b0101, data_ack 1 cycle later.
  - The read returns 0xAA22CC44.
- Both requests asserted in the same cycle after reset:
  - instr is granted first, data in the next cycle (during ACK_I).
  - Held continuously, the pattern over 8 cycles is I,D,I,D,I,D,I,D.
  - mem_en=1 in every cycle.
- FIXED_PRIORITY=1, both requesting continuously:
  - data is granted every other cycle.
  - instr is granted only in data's ack cycles.
  - No cycle has both acks high.
- Assert rstz=0 asynchronously, mid-cycle, while data_ack=1:
  - data_ack drops immediately without waiting for a clock edge.
  - After release with both requesting, instr wins first.
- Data write with mask=4'b0000 to a word holding 0x12345678:
  - data_ack=1 after 1 cycle.
  - A subsequent read returns 0x12345678.
